// File: rtl/cipher_sequencer_if.sv
// Control/status bundle between the cipher sequencer and the datapath/board I/O.
// master = sequencer side, slave = datapath/board side.
interface cipher_sequencer_if;
    logic       btn_start;
    logic [1:0] sw_key;
    logic       encry_completed;
    logic       copy_completed;
    logic       en_encryption;
    logic       clr_RAM;
    logic       en_copier;
    logic [1:0] key;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        input  btn_start, sw_key, encry_completed, copy_completed,
        output en_encryption, clr_RAM, en_copier, key, busy, done, error
    );

    modport slave (
        output btn_start, sw_key, encry_completed, copy_completed,
        input  en_encryption, clr_RAM, en_copier, key, busy, done, error
    );
endinterface

// File: rtl/cipher_sequencer.sv
// Run controller for the cipher datapath: debounced start, key latch,
// CLEAR -> ENCRYPT -> COPY sequencing with completion dwell and timeout.
module cipher_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CLR_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES  = 1048576,
    parameter int MIN_DWELL       = 2
) (
    input logic              clk,
    input logic              reset,
    cipher_sequencer_if.master io
);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CLW = (CLR_CYCLES > 1)      ? $clog2(CLR_CYCLES)      : 1;
    localparam int TOW = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam int DWW = (MIN_DWELL > 1)       ? $clog2(MIN_DWELL)       : 1;

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CLW-1:0] CLR_LAST = CLW'(CLR_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [DWW-1:0] DW_LAST  = DWW'((MIN_DWELL > 0) ? MIN_DWELL - 1 : 0);
    localparam logic           NO_DWELL = (MIN_DWELL == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ENCRYPT, S_COPY, S_DONE, S_ERROR
    } state_e;

    state_e         state_q, state_d;
    logic           btn_s1_q, btn_s2_q, btn_acc_q, btn_acc_d, btn_acc_prev_q;
    logic [1:0]     key_s1_q, key_s2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [CLW-1:0] clr_cnt_q, clr_cnt_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [DWW-1:0] dw_cnt_q, dw_cnt_d;
    logic           dw_ok_q, dw_ok_d;
    logic [1:0]     key_q, key_d;
    logic           en_enc_q, en_enc_d, clr_q, clr_d, en_cop_q, en_cop_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           start_pulse;
    logic           phase_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            btn_s1_q       <= 1'b0;
            btn_s2_q       <= 1'b0;
            btn_acc_q      <= 1'b0;
            btn_acc_prev_q <= 1'b0;
            key_s1_q       <= '0;
            key_s2_q       <= '0;
            db_cnt_q       <= '0;
            clr_cnt_q      <= '0;
            to_cnt_q       <= '0;
            dw_cnt_q       <= '0;
            dw_ok_q        <= 1'b0;
            key_q          <= '0;
            en_enc_q       <= 1'b0;
            clr_q          <= 1'b0;
            en_cop_q       <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            btn_s1_q       <= io.btn_start;
            btn_s2_q       <= btn_s1_q;
            btn_acc_q      <= btn_acc_d;
            btn_acc_prev_q <= btn_acc_q;
            key_s1_q       <= io.sw_key;
            key_s2_q       <= key_s1_q;
            db_cnt_q       <= db_cnt_d;
            clr_cnt_q      <= clr_cnt_d;
            to_cnt_q       <= to_cnt_d;
            dw_cnt_q       <= dw_cnt_d;
            dw_ok_q        <= dw_ok_d;
            key_q          <= key_d;
            en_enc_q       <= en_enc_d;
            clr_q          <= clr_d;
            en_cop_q       <= en_cop_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        btn_acc_d = btn_acc_q;
        db_cnt_d  = '0;
        if (btn_s2_q != btn_acc_q) begin
            if (db_cnt_q == DB_LAST) btn_acc_d = btn_s2_q;
            else                     db_cnt_d  = db_cnt_q + 1'b1;
        end
        start_pulse = btn_acc_q & ~btn_acc_prev_q;

        state_d    = state_q;
        key_d      = key_q;
        clr_cnt_d  = clr_cnt_q;
        to_cnt_d   = to_cnt_q + 1'b1;
        dw_cnt_d   = dw_cnt_q;
        dw_ok_d    = dw_ok_q;
        phase_done = (state_q == S_ENCRYPT) ? io.encry_completed : io.copy_completed;
        if (!dw_ok_q) begin
            if (dw_cnt_q == DW_LAST) dw_ok_d  = 1'b1;
            else                     dw_cnt_d = dw_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_pulse) begin
                    state_d   = S_CLEAR;
                    key_d     = key_s2_q;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) state_d   = S_ENCRYPT;
                else                       clr_cnt_d = clr_cnt_q + 1'b1;
            end
            S_ENCRYPT, S_COPY: begin
                // completion is checked before timeout so a tie ends successfully
                if (dw_ok_q && phase_done)
                    state_d = (state_q == S_ENCRYPT) ? S_COPY : S_DONE;
                else if (to_cnt_q == TO_LAST)
                    state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            to_cnt_d = '0;
            dw_cnt_d = '0;
            dw_ok_d  = NO_DWELL;
        end

        en_enc_d = 1'b0;
        clr_d    = 1'b0;
        en_cop_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_d)
            S_CLEAR:   begin clr_d    = 1'b1; busy_d = 1'b1; end
            S_ENCRYPT: begin en_enc_d = 1'b1; busy_d = 1'b1; end
            S_COPY:    begin en_cop_d = 1'b0; busy_d = 1'b1; end
            S_DONE:    done_d = 1'b1;
            S_ERROR:   err_d  = 1'b1;
            default:   ;
        endcase
    end

    assign io.en_encryption = en_enc_q;
    assign io.clr_RAM       = clr_q;
    assign io.en_copier     = en_cop_q;
    assign io.key           = key_q;
    assign io.busy          = busy_q;
    assign io.done          = done_q;
    assign io.error         = err_q;
endmodule
